yavas_sayac_cozucu: RTL and testbench



---
 rtl/sayac_pkg.sv | 28 ++
 rtl/sayac_adim_siniflandir.sv | 66 ++++++
 rtl/yavas_sayac_cozucu.sv | 143 ++++++++++++++
 tb/tb_yavas_sayac_cozucu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sayac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sayac_pkg
// Description : Definitions shared by the slow up/down counter and its
//               decoder. Holds the default widths and the decoder state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sayac_pkg;

  localparam int VARSAYILAN_SAYAC_W   = 6;
  localparam int VARSAYILAN_MIKTAR_W  = 3;
  localparam int VARSAYILAN_PERIYOT_W = 16;

  // BOS: first sample after reset, ILK: no change seen yet, IZLE: tracking
  typedef enum logic [1:0] {
    BOS  = 2'd0,
    ILK  = 2'd1,
    IZLE = 2'd2
  } durum_t;

  // Largest legal step magnitude for a given step width
  function automatic int azami_adim(input int miktar_w);
    return (1 << miktar_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sayac_adim_siniflandir.sv
`default_nettype none
// ============================================================================
// Module      : sayac_adim_siniflandir
// Description : Purely combinational step classifier. Given the previous and
//               current counter values it reports whether the change is a
//               legal up/down step (and its size), a jump to zero caused by a
//               counter reset, or an illegal jump. Equal inputs give no flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sayac_adim_siniflandir
  import sayac_pkg::*;
#(
  parameter int SAYAC_W  = VARSAYILAN_SAYAC_W,
  parameter int MIKTAR_W = VARSAYILAN_MIKTAR_W
) (
  input  logic [SAYAC_W-1:0]  onceki,
  input  logic [SAYAC_W-1:0]  sayac_in,
  output logic                legal,
  output logic                yon,
  output logic [MIKTAR_W-1:0] miktar,
  output logic                sifir,
  output logic                hata
);

  localparam logic [SAYAC_W-1:0] AZAMI_ADIM = SAYAC_W'(azami_adim(MIKTAR_W));

  // Both differences are taken modulo 2^SAYAC_W so wrap-around steps
  // (e.g. 62 -> 3) look like ordinary small steps.
  logic [SAYAC_W-1:0] ileri;
  logic [SAYAC_W-1:0] geri;
  logic               degisti;
  logic               ileri_ok;
  logic               geri_ok;

  assign ileri    = sayac_in - onceki;
  assign geri     = onceki - sayac_in;
  assign degisti  = (sayac_in != onceki);
  assign ileri_ok = (ileri != '0) && (ileri <= AZAMI_ADIM);
  assign geri_ok  = (geri  != '0) && (geri  <= AZAMI_ADIM);

  // Priority: up step, down step, jump to zero, anything else is illegal
  always_comb begin
    legal  = 1'b0;
    yon    = 1'b1;
    miktar = '0;
    sifir  = 1'b0;
    hata   = 1'b0;
    if (degisti) begin
      if (ileri_ok) begin
        legal  = 1'b1;
        yon    = 1'b1;
        miktar = ileri[MIKTAR_W-1:0];
      end else if (geri_ok) begin
        legal  = 1'b1;
        yon    = 1'b0;
        miktar = geri[MIKTAR_W-1:0];
      end else if (sayac_in == '0) begin
        sifir  = 1'b1;
      end else begin
        hata   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/yavas_sayac_cozucu.sv
`default_nettype none
// ============================================================================
// Module      : yavas_sayac_cozucu
// Description : Decoder for the slow up/down counter. Samples the counter
//               value every clock, recovers direction and step size of each
//               update, flags counter-reset jumps and illegal jumps, and
//               measures the number of cycles between accepted changes.
// Revision    : 1.0 - initial release
// ============================================================================
module yavas_sayac_cozucu
  import sayac_pkg::*;
#(
  parameter int SAYAC_W   = VARSAYILAN_SAYAC_W,
  parameter int MIKTAR_W  = VARSAYILAN_MIKTAR_W,
  parameter int PERIYOT_W = VARSAYILAN_PERIYOT_W
) (
  input  logic                 clk,
  input  logic                 sifirlama,
  input  logic [SAYAC_W-1:0]   sayac_in,
  output logic                 yon,
  output logic [MIKTAR_W-1:0]  miktar,
  output logic                 gecerli,
  output logic                 sifir_gordu,
  output logic                 hata,
  output logic [PERIYOT_W-1:0] periyot,
  output logic                 periyot_gecerli
);

  durum_t               durum;
  durum_t               durum_n;
  logic [SAYAC_W-1:0]   onceki;
  logic [SAYAC_W-1:0]   onceki_n;
  logic [PERIYOT_W-1:0] aralik;
  logic [PERIYOT_W-1:0] aralik_n;
  logic [PERIYOT_W-1:0] aralik_doygun;

  logic                 yon_n;
  logic [MIKTAR_W-1:0]  miktar_n;
  logic                 gecerli_n;
  logic                 sifir_gordu_n;
  logic                 hata_n;
  logic [PERIYOT_W-1:0] periyot_n;
  logic                 periyot_gecerli_n;

  logic                 adim_legal;
  logic                 adim_yon;
  logic [MIKTAR_W-1:0]  adim_miktar;
  logic                 adim_sifir;
  logic                 adim_hata;

  sayac_adim_siniflandir #(
    .SAYAC_W  (SAYAC_W),
    .MIKTAR_W (MIKTAR_W)
  ) u_siniflandir (
    .onceki   (onceki),
    .sayac_in (sayac_in),
    .legal    (adim_legal),
    .yon      (adim_yon),
    .miktar   (adim_miktar),
    .sifir    (adim_sifir),
    .hata     (adim_hata)
  );

  // The cycle counter sticks at all-ones so very long holds never wrap
  assign aralik_doygun = (aralik == '1) ? aralik : aralik + PERIYOT_W'(1);

  // State register and all registered outputs
  always_ff @(posedge clk or posedge sifirlama) begin
    if (sifirlama) begin
      durum           <= BOS;
      onceki          <= '0;
      aralik          <= '0;
      yon             <= 1'b1;
      miktar          <= '0;
      gecerli         <= 1'b0;
      sifir_gordu     <= 1'b0;
      hata            <= 1'b0;
      periyot         <= '0;
      periyot_gecerli <= 1'b0;
    end else begin
      durum           <= durum_n;
      onceki          <= onceki_n;
      aralik          <= aralik_n;
      yon             <= yon_n;
      miktar          <= miktar_n;
      gecerli         <= gecerli_n;
      sifir_gordu     <= sifir_gordu_n;
      hata            <= hata_n;
      periyot         <= periyot_n;
      periyot_gecerli <= periyot_gecerli_n;
    end
  end

  // Next-state and output decode; pulses default low, everything else holds
  always_comb begin
    durum_n           = durum;
    onceki_n          = onceki;
    aralik_n          = aralik;
    yon_n             = yon;
    miktar_n          = miktar;
    gecerli_n         = 1'b0;
    sifir_gordu_n     = 1'b0;
    hata_n            = 1'b0;
    periyot_n         = periyot;
    periyot_gecerli_n = periyot_gecerli;

    case (durum)
      BOS: begin
        // The first sample after reset only seeds the reference value
        onceki_n = sayac_in;
        aralik_n = '0;
        durum_n  = ILK;
      end
      ILK, IZLE: begin
        if (sayac_in == onceki) begin
          aralik_n = aralik_doygun;
        end else begin
          if (adim_legal) begin
            yon_n     = adim_yon;
            miktar_n  = adim_miktar;
            gecerli_n = 1'b1;
          end
          sifir_gordu_n = adim_sifir;
          hata_n        = adim_hata;
          // The interval before the very first change has no known start
          // point, so it is not reported as a period.
          if (durum == IZLE) begin
            periyot_n         = aralik;
            periyot_gecerli_n = 1'b1;
          end
          onceki_n = sayac_in;
          aralik_n = PERIYOT_W'(1);
          durum_n  = IZLE;
        end
      end
      default: begin
        durum_n = BOS;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_yavas_sayac_cozucu.sv
`default_nettype none
// ============================================================================
// Module      : tb_yavas_sayac_cozucu
// Description : Self-checking bench for yavas_sayac_cozucu. A behavioural
//               model predicts the outputs for every driven sample; the
//               prediction is queued and compared once the DUT has clocked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yavas_sayac_cozucu;

  logic        clk;
  logic        sifirlama;
  logic [5:0]  sayac_in;
  logic        yon;
  logic [2:0]  miktar;
  logic        gecerli;
  logic        sifir_gordu;
  logic        hata;
  logic [15:0] periyot;
  logic        periyot_gecerli;

  typedef struct packed {
    logic        yon;
    logic [2:0]  miktar;
    logic        gecerli;
    logic        sifir_gordu;
    logic        hata;
    logic [15:0] periyot;
    logic        periyot_gecerli;
  } gozlem_t;

  gozlem_t sb[$];
  int      n_pass;
  int      n_total;

  // Model state
  int         m_durum;   // 0 first sample, 1 no change yet, 2 tracking
  logic [5:0] m_onceki;
  int         m_aralik;
  gozlem_t    m_cikis;

  yavas_sayac_cozucu dut (
    .clk             (clk),
    .sifirlama       (sifirlama),
    .sayac_in        (sayac_in),
    .yon             (yon),
    .miktar          (miktar),
    .gecerli         (gecerli),
    .sifir_gordu     (sifir_gordu),
    .hata            (hata),
    .periyot         (periyot),
    .periyot_gecerli (periyot_gecerli)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_durum  = 0;
    m_onceki = '0;
    m_aralik = 0;
    m_cikis  = '{yon: 1'b1, miktar: 3'd0, gecerli: 1'b0, sifir_gordu: 1'b0,
                 hata: 1'b0, periyot: 16'd0, periyot_gecerli: 1'b0};
  endtask

  task automatic model_step(input logic [5:0] v);
    logic [5:0] up;
    logic [5:0] dn;
    m_cikis.gecerli     = 1'b0;
    m_cikis.sifir_gordu = 1'b0;
    m_cikis.hata        = 1'b0;
    if (m_durum == 0) begin
      m_onceki = v;
      m_aralik = 0;
      m_durum  = 1;
    end else if (v == m_onceki) begin
      if (m_aralik < 65535) m_aralik = m_aralik + 1;
    end else begin
      up = v - m_onceki;
      dn = m_onceki - v;
      if (up >= 6'd1 && up <= 6'd7) begin
        m_cikis.yon = 1'b1; m_cikis.miktar = up[2:0]; m_cikis.gecerli = 1'b1;
      end else if (dn >= 6'd1 && dn <= 6'd7) begin
        m_cikis.yon = 1'b0; m_cikis.miktar = dn[2:0]; m_cikis.gecerli = 1'b1;
      end else if (v == 6'd0) begin
        m_cikis.sifir_gordu = 1'b1;
      end else begin
        m_cikis.hata = 1'b1;
      end
      if (m_durum == 2) begin
        m_cikis.periyot         = 16'(m_aralik);
        m_cikis.periyot_gecerli = 1'b1;
      end
      m_aralik = 1;
      m_onceki = v;
      m_durum  = 2;
    end
  endtask

  function automatic gozlem_t gozle();
    gozlem_t g;
    g = '{yon: yon, miktar: miktar, gecerli: gecerli, sifir_gordu: sifir_gordu,
          hata: hata, periyot: periyot, periyot_gecerli: periyot_gecerli};
    return g;
  endfunction

  task automatic check_obs(input string tag);
    gozlem_t exp;
    gozlem_t obs;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    exp = sb.pop_front();
    obs = gozle();
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive one sample between edges, queue the prediction, check after the edge
  task automatic tick(input logic [5:0] v, input logic r, input string tag);
    @(negedge clk);
    sifirlama = r;
    sayac_in  = v;
    if (r) model_reset();
    else   model_step(v);
    sb.push_back(m_cikis);
    @(posedge clk);
    #1;
    check_obs(tag);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    sifirlama = 1'b1;
    sayac_in  = 6'd0;
    model_reset();
    #1;
    sb.push_back(m_cikis);
    check_obs("reset_state");
    check_val("reset_yon", {31'd0, yon}, 32'd1);

    // Hold 10, then step up by 5; first change gives no period
    tick(6'd0, 1'b1, "in_reset");
    for (int i = 0; i < 6; i++) tick(6'd10, 1'b0, "hold10");
    tick(6'd15, 1'b0, "up5");
    check_val("up5_gecerli", {31'd0, gecerli}, 32'd1);
    check_val("up5_yon", {31'd0, yon}, 32'd1);
    check_val("up5_miktar", {29'd0, miktar}, 32'd5);
    check_val("up5_pg", {31'd0, periyot_gecerli}, 32'd0);

    // Down 2 then up 7, each after the previous value was present 4 cycles
    for (int i = 0; i < 3; i++) tick(6'd15, 1'b0, "hold15");
    tick(6'd13, 1'b0, "down2");
    check_val("down2_yon", {31'd0, yon}, 32'd0);
    check_val("down2_miktar", {29'd0, miktar}, 32'd2);
    check_val("down2_periyot", {16'd0, periyot}, 32'd4);
    check_val("down2_pg", {31'd0, periyot_gecerli}, 32'd1);
    for (int i = 0; i < 3; i++) tick(6'd13, 1'b0, "hold13");
    tick(6'd20, 1'b0, "up7");
    check_val("up7_yon", {31'd0, yon}, 32'd1);
    check_val("up7_miktar", {29'd0, miktar}, 32'd7);
    check_val("up7_periyot", {16'd0, periyot}, 32'd4);
    tick(6'd20, 1'b0, "hold20");

    // Wrap-around steps in both directions
    tick(6'd62, 1'b0, "to62");
    tick(6'd62, 1'b0, "hold62");
    tick(6'd3, 1'b0, "wrap_up");
    check_val("wrap_up_miktar", {29'd0, miktar}, 32'd5);
    check_val("wrap_up_hata", {31'd0, hata}, 32'd0);
    tick(6'd3, 1'b0, "hold3");
    tick(6'd62, 1'b0, "wrap_down");
    check_val("wrap_down_yon", {31'd0, yon}, 32'd0);
    check_val("wrap_down_hata", {31'd0, hata}, 32'd0);

    // Counter reset jump and an illegal jump
    tick(6'd40, 1'b0, "to40");
    tick(6'd40, 1'b0, "hold40");
    tick(6'd0, 1'b0, "zero_jump");
    check_val("zero_jump_flag", {31'd0, sifir_gordu}, 32'd1);
    check_val("zero_jump_gecerli", {31'd0, gecerli}, 32'd0);
    tick(6'd30, 1'b0, "illegal");
    check_val("illegal_flag", {31'd0, hata}, 32'd1);

    // Back-to-back steps
    tick(6'd31, 1'b0, "b2b_a");
    tick(6'd33, 1'b0, "b2b_b");
    check_val("b2b_periyot", {16'd0, periyot}, 32'd1);

    // Long hold saturates the period counter
    for (int i = 0; i < 70000; i++) tick(6'd33, 1'b0, "long_hold");
    tick(6'd36, 1'b0, "after_hold");
    check_val("sat_periyot", {16'd0, periyot}, 32'd65535);

    // Asynchronous reset between edges, then release
    tick(6'd37, 1'b0, "pre_rst");
    tick(6'd37, 1'b0, "pre_rst_hold");
    @(posedge clk);
    #3;
    sifirlama = 1'b1;
    model_reset();
    #1;
    sb.push_back(m_cikis);
    check_obs("async_reset");
    check_val("async_reset_yon", {31'd0, yon}, 32'd1);
    tick(6'd37, 1'b1, "rst_held");
    tick(6'd50, 1'b0, "first_after_rst");
    check_val("first_after_rst_flags", {29'd0, gecerli, sifir_gordu, hata}, 32'd0);
    tick(6'd50, 1'b0, "hold50");
    tick(6'd52, 1'b0, "step_after_rst");
    check_val("step_after_rst_gecerli", {31'd0, gecerli}, 32'd1);
    check_val("step_after_rst_pg", {31'd0, periyot_gecerli}, 32'd0);
    tick(6'd54, 1'b0, "step2_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
